// File: rtl/tia_playfield_registers_cell.sv
// ---------------------------------------------------------------------------
// tia_playfield_registers_cell
//   Three-cell playfield register slice. A free-running 2-bit phase counter
//   produces non-overlapping biphase strobes (phi1 at count 0, phi2 at
//   count 2). Forward tokens enter the upper cell on si1 and move downwards.
//   Reverse tokens enter the lower cell on si2 and move upwards. Each cell is
//   a master/slave pair: the master samples on phi1 and the slave on phi2.
//   A cell drives its output while its latched data bit is set and either
//   slave holds a token.
//
// Ports
//   clk     in   master clock, rising edge
//   r       in   synchronous active-low reset
//   rsyn    in   phase resync request (forces counter to 3)
//   i[2:0]  in   playfield data, i[0] = upper cell, i[2] = lower cell
//   l1      in   data follow/load enable (hold when low)
//   si1     in   forward token into upper cell
//   si2     in   reverse token into lower cell
//   phi1    out  strobe, high while counter == 0
//   phi2    out  strobe, high while counter == 2
//   rl      out  rsyn as sampled on the last phi1 edge
//   so1     out  forward token leaving lower cell
//   so2     out  reverse token leaving upper cell
//   o[2:0]  out  per-cell playfield outputs
//   out     out  OR of o
// ---------------------------------------------------------------------------
module tia_playfield_registers_cell (
    input  logic       clk,
    input  logic       r,
    input  logic       rsyn,
    input  logic [2:0] i,
    input  logic       l1,
    input  logic       si1,
    input  logic       si2,
    output logic       phi1,
    output logic       phi2,
    output logic       rl,
    output logic       so1,
    output logic       so2,
    output logic [2:0] o,
    output logic       out
);

    logic [1:0] cnt_q, cnt_d;
    logic       rl_q, rl_d;
    logic [2:0] dat_q, dat_d;
    logic [2:0] fm_q, fm_d;
    logic [2:0] fs_q, fs_d;
    logic [2:0] rm_q, rm_d;
    logic [2:0] rs_q, rs_d;
    logic       l2;

    // Hold enable is the complement of the follow enable.
    assign l2   = ~l1;

    assign phi1 = (cnt_q == 2'd0);
    assign phi2 = (cnt_q == 2'd2);

    always_comb begin
        // Resync parks the counter at 3 so phi1 fires right after rsyn drops.
        cnt_d = rsyn ? 2'd3 : cnt_q + 2'd1;
        rl_d  = phi1 ? rsyn : rl_q;
        dat_d = l2 ? dat_q : i;
        // Forward chain: cell k master takes the slave of the cell above.
        fm_d  = phi1 ? {fs_q[1:0], si1} : fm_q;
        fs_d  = phi2 ? fm_q : fs_q;
        // Reverse chain: cell k master takes the slave of the cell below.
        rm_d  = phi1 ? {si2, rs_q[2:1]} : rm_q;
        rs_d  = phi2 ? rm_q : rs_q;
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            cnt_q <= 2'd3;
            rl_q  <= 1'b0;
            dat_q <= 3'b000;
            fm_q  <= 3'b000;
            fs_q  <= 3'b000;
            rm_q  <= 3'b000;
            rs_q  <= 3'b000;
        end else begin
            cnt_q <= cnt_d;
            rl_q  <= rl_d;
            dat_q <= dat_d;
            fm_q  <= fm_d;
            fs_q  <= fs_d;
            rm_q  <= rm_d;
            rs_q  <= rs_d;
        end
    end

    assign rl  = rl_q;
    assign o   = dat_q & (fs_q | rs_q);
    assign out = |o;
    assign so1 = fs_q[2];
    assign so2 = rs_q[0];

endmodule

// File: tb/tb_tia_playfield_registers_cell.sv
module tb_tia_playfield_registers_cell;

    logic       clk = 1'b0;
    logic       r, rsyn, l1, si1, si2;
    logic [2:0] i;
    logic       phi1, phi2, rl, so1, so2, out;
    logic [2:0] o;

    int nerr = 0;
    int nchk = 0;

    tia_playfield_registers_cell dut (
        .clk(clk), .r(r), .rsyn(rsyn), .i(i), .l1(l1), .si1(si1), .si2(si2),
        .phi1(phi1), .phi2(phi2), .rl(rl), .so1(so1), .so2(so2), .o(o), .out(out)
    );

    always #5 clk = ~clk;

    // Reference model: integer phase plus per-cell token occupancy tables.
    int  phase;
    bit  m_rl;
    bit  m_dat [3];
    bit  f_mst [3], f_slv [3];
    bit  r_mst [3], r_slv [3];

    task automatic model_edge();
        bit nf [3];
        bit nr [3];
        bit p1, p2;
        if (!r) begin
            phase = 3; m_rl = 0;
            for (int k = 0; k < 3; k++) begin
                m_dat[k] = 0; f_mst[k] = 0; f_slv[k] = 0; r_mst[k] = 0; r_slv[k] = 0;
            end
            return;
        end
        p1 = (phase == 0);
        p2 = (phase == 2);
        if (p1) begin
            m_rl = rsyn;
            for (int k = 0; k < 3; k++) begin
                nf[k] = (k == 0) ? si1 : f_slv[k-1];
                nr[k] = (k == 2) ? si2 : r_slv[k+1];
            end
            f_mst = nf;
            r_mst = nr;
        end
        if (p2) begin
            f_slv = f_mst;
            r_slv = r_mst;
        end
        if (l1) for (int k = 0; k < 3; k++) m_dat[k] = i[k];
        phase = rsyn ? 3 : (phase + 1) % 4;
    endtask

    function automatic logic [8:0] model_out();
        logic [2:0] eo;
        for (int k = 0; k < 3; k++) eo[k] = m_dat[k] && (f_slv[k] || r_slv[k]);
        return {phase == 0, phase == 2, m_rl, f_slv[2], r_slv[0], eo, |eo};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: model follows the posedge, outputs compared at the negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag, {phi1, phi2, rl, so1, so2, o, out}, model_out());
    endtask

    task automatic align_phi1();
        int n = 0;
        while (phase != 0 && n < 8) begin
            step("align");
            n++;
        end
        nchk++;
        if (phase != 0) begin
            nerr++;
            $error("FAIL align_timeout observed=%0d expected=0", phase);
        end
    endtask

    int hits;

    initial begin
        phase = 3;
        r = 0; rsyn = 0; l1 = 0; si1 = 0; si2 = 0; i = 3'b000;
        @(negedge clk);

        // Reset held for three clocks: all outputs quiet.
        for (int c = 0; c < 3; c++) begin
            step("reset");
            check("reset_zero", {phi1, phi2, so1, so2, o, out, rl}, 9'd0);
        end

        // Release: phi1 on the first cycle, phi2 two later, repeating every 4.
        r = 1;
        for (int c = 1; c <= 9; c++) begin
            step("release");
            check("phase_pattern", {7'd0, phi1, phi2},
                  {7'd0, (c % 4) == 1, (c % 4) == 3});
        end

        // Forward hit on the upper cell: out high for one full phase period.
        i = 3'b001; l1 = 1; step("latch"); l1 = 0; i = 3'b110;
        align_phi1();
        si1 = 1;
        hits = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 4) si1 = 0;
            step("fwd_hit");
            if (out) hits++;
        end
        check("fwd_hit_len", 9'(hits), 9'd4);

        // Reverse hit travels through cells 2,1 silently, then lights cell 0.
        align_phi1();
        si2 = 1;
        hits = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 4) si2 = 0;
            step("rev_hit");
            if (out) hits++;
            check("rev_low_cells", {7'd0, o[2:1]}, 9'd0);
        end
        check("rev_hit_len", 9'(hits), 9'd4);

        // Resync raised during a phi1 cycle for two clocks.
        align_phi1();
        rsyn = 1; step("rsyn"); step("rsyn"); rsyn = 0;
        step("rsyn_drop");
        check("rsyn_phi1", {8'd0, phi1}, 9'd1);
        check("rsyn_rl", {8'd0, rl}, 9'd1);

        // Mid-propagation reset with a token in flight.
        i = 3'b111; l1 = 1; step("latch_all"); l1 = 0;
        align_phi1();
        si1 = 1; si2 = 1;
        for (int c = 0; c < 6; c++) step("inflight");
        si1 = 0; si2 = 0;
        r = 0; step("mid_reset"); r = 1;
        check("mid_reset_zero", {phi1, phi2, so1, so2, o, out, rl}, 9'd0);
        for (int c = 0; c < 12; c++) begin
            step("post_reset");
            check("post_reset_out", {7'd0, out, so1 | so2}, 9'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            si1  = ($urandom_range(0, 3) == 0);
            si2  = ($urandom_range(0, 3) == 0);
            l1   = ($urandom_range(0, 7) == 0);
            i    = 3'($urandom);
            rsyn = ($urandom_range(0, 19) == 0);
            r    = ($urandom_range(0, 99) != 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
